// File: rtl/pkt_defs_pkg.sv
// Shared flit-format definitions for the egress packet buffer.
// Describes the flit layout, the flit type codes and the FSM state encodings.
package pkt_defs_pkg;

  // Flit width and the location of the 2-bit type field.
  localparam int FLIT_W  = 134;
  localparam int TYPE_HI = 133;
  localparam int TYPE_LO = 132;

  // Flit type codes carried in bits [133:132].
  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  // Write side: waiting for a head, or inside a packet.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_PKT  = 1'b1
  } wr_state_e;

  // Read side: waiting for a committed packet and a grant, or replaying one.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_e;

  // Extracts the type field of a flit.
  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[TYPE_HI:TYPE_LO]);
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Simple dual-port flit RAM with a registered read port.
// This is the vendor-swappable storage; the read register is reset so the
// buffer's data output is zero straight out of reset.
module pkt_buf_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 134
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port: store one flit per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: one-cycle latency; holds the last flit read when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pkt_egress_buffer.sv
// Store-and-forward egress buffer behind the packet mux.
// Incoming packets are written speculatively and only become visible to the
// reader once their tail arrives with a keep status; anything else rewinds the
// write pointer to the last commit point. The reader replays one committed
// packet per grant, back to back with at least one idle cycle in between.
module pkt_egress_buffer
  import pkt_defs_pkg::*;
#(
  parameter int DEPTH_LOG2    = 9,
  parameter int MAX_PKT_FLITS = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_data_wr,
  input  logic [FLIT_W-1:0] in_data,
  input  logic              in_data_valid_wr,
  input  logic              in_data_valid,
  output logic              in_ready,
  output logic              out_data_wr,
  output logic [FLIT_W-1:0] out_data,
  output logic              out_data_valid_wr,
  output logic              out_data_valid,
  input  logic              out_ready,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       drop_cnt
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(1 << DEPTH_LOG2);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_PKT_FLITS);

  wr_state_e w_state_reg, w_state_next;
  rd_state_e r_state_reg, r_state_next;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] commit_ptr_reg, commit_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] pkts_avail_reg, pkts_avail_next;
  logic          trunc_reg, trunc_next;
  logic          in_ready_reg;
  logic          out_wr_reg;
  logic [31:0]   pkt_cnt_reg, drop_cnt_reg;

  logic                  ram_wr_en;
  logic [DEPTH_LOG2-1:0] ram_wr_addr;
  logic                  ram_rd_en;
  logic [FLIT_W-1:0]     ram_rd_data;

  logic          commit_evt;
  logic          drop_evt;
  logic          tail_out_evt;
  logic          out_tail;
  logic [PW-1:0] fill;
  logic [PW-1:0] fill_rb;
  logic          full;
  logic          full_rb;
  flit_type_e    in_type;
  flit_type_e    out_type;

  assign in_type  = flit_type(in_data);
  assign out_type = flit_type(ram_rd_data);

  // Occupancy including uncommitted flits, and occupancy after a rollback.
  assign fill    = wr_ptr_reg - rd_ptr_reg;
  assign fill_rb = commit_ptr_reg - rd_ptr_reg;
  assign full    = (fill == DEPTH_P);
  assign full_rb = (fill_rb == DEPTH_P);

  // The flit currently on the output is a tail: this ends the replay.
  assign out_tail = out_wr_reg && (out_type == FLIT_TAIL);

  pkt_buf_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (FLIT_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (in_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
    .rd_data (ram_rd_data)
  );

  // Write FSM next state: speculative write, commit on a good tail, rollback otherwise.
  always_comb begin
    w_state_next    = w_state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    trunc_next      = trunc_reg;
    ram_wr_en       = 1'b0;
    ram_wr_addr     = wr_ptr_reg[DEPTH_LOG2-1:0];
    commit_evt      = 1'b0;
    drop_evt        = 1'b0;
    if (in_data_wr) begin
      unique case (w_state_reg)
        W_IDLE: begin
          // Only a head opens a packet; stray body/tail/reserved flits are ignored.
          if (in_type == FLIT_HEAD) begin
            w_state_next = W_PKT;
            trunc_next   = full;
            if (!full) begin
              ram_wr_en   = 1'b1;
              wr_ptr_next = wr_ptr_reg + 1'b1;
            end
          end
        end
        W_PKT: begin
          case (in_type)
            FLIT_BODY: begin
              if (full) begin
                trunc_next = 1'b1;
              end else begin
                ram_wr_en   = 1'b1;
                wr_ptr_next = wr_ptr_reg + 1'b1;
              end
            end
            FLIT_TAIL: begin
              ram_wr_en    = !full;
              trunc_next   = 1'b0;
              w_state_next = W_IDLE;
              if (in_data_valid_wr && in_data_valid && !trunc_reg && !full) begin
                wr_ptr_next     = wr_ptr_reg + 1'b1;
                commit_ptr_next = wr_ptr_reg + 1'b1;
                commit_evt      = 1'b1;
              end else begin
                wr_ptr_next = commit_ptr_reg;
                drop_evt    = 1'b1;
              end
            end
            FLIT_HEAD: begin
              // Missing tail: discard the partial packet and restart at the commit point.
              drop_evt    = 1'b1;
              ram_wr_addr = commit_ptr_reg[DEPTH_LOG2-1:0];
              trunc_next  = full_rb;
              if (full_rb) begin
                wr_ptr_next = commit_ptr_reg;
              end else begin
                ram_wr_en   = 1'b1;
                wr_ptr_next = commit_ptr_reg + 1'b1;
              end
            end
            default: begin
              // Reserved type inside a packet carries no meaning; drop the flit.
            end
          endcase
        end
        default: begin
          w_state_next = W_IDLE;
        end
      endcase
    end
  end

  // Read FSM next state: start on a grant, read every cycle until the tail shows up.
  always_comb begin
    r_state_next = r_state_reg;
    rd_ptr_next  = rd_ptr_reg;
    ram_rd_en    = 1'b0;
    tail_out_evt = 1'b0;
    unique case (r_state_reg)
      R_IDLE: begin
        if ((pkts_avail_reg != '0) && out_ready) begin
          ram_rd_en    = 1'b1;
          rd_ptr_next  = rd_ptr_reg + 1'b1;
          r_state_next = R_SEND;
        end
      end
      R_SEND: begin
        // The tail is seen one cycle after it was read, so stop reading there.
        if (out_tail) begin
          tail_out_evt = 1'b1;
          r_state_next = R_IDLE;
        end else begin
          ram_rd_en   = 1'b1;
          rd_ptr_next = rd_ptr_reg + 1'b1;
        end
      end
      default: begin
        r_state_next = R_IDLE;
      end
    endcase
  end

  // Committed-packet count: a commit and a tail-out in the same cycle cancel.
  always_comb begin
    pkts_avail_next = pkts_avail_reg;
    case ({commit_evt, tail_out_evt})
      2'b10:   pkts_avail_next = pkts_avail_reg + 1'b1;
      2'b01:   pkts_avail_next = pkts_avail_reg - 1'b1;
      default: pkts_avail_next = pkts_avail_reg;
    endcase
  end

  // State, pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg    <= W_IDLE;
      r_state_reg    <= R_IDLE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      pkts_avail_reg <= '0;
      trunc_reg      <= 1'b0;
      in_ready_reg   <= 1'b0;
      out_wr_reg     <= 1'b0;
      pkt_cnt_reg    <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      w_state_reg    <= w_state_next;
      r_state_reg    <= r_state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      pkts_avail_reg <= pkts_avail_next;
      trunc_reg      <= trunc_next;
      in_ready_reg   <= (DEPTH_P - fill) >= MAX_P;
      out_wr_reg     <= ram_rd_en;
      if (commit_evt) begin
        pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      end
      if (drop_evt) begin
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
    end
  end

  assign in_ready          = in_ready_reg;
  assign out_data_wr       = out_wr_reg;
  assign out_data          = ram_rd_data;
  assign out_data_valid_wr = out_tail;
  assign out_data_valid    = out_tail;
  assign pkt_cnt           = pkt_cnt_reg;
  assign drop_cnt          = drop_cnt_reg;

endmodule

// File: tb/tb_pkt_egress_buffer.sv
// Scoreboard bench for pkt_egress_buffer, built with a 16-flit buffer and an
// 8-flit worst-case packet so that truncation is reachable.
module tb_pkt_egress_buffer;

  localparam int DL   = 4;
  localparam int MAXF = 8;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         in_data_valid_wr;
  logic         in_data_valid;
  logic         in_ready;
  logic         out_data_wr;
  logic [133:0] out_data;
  logic         out_data_valid_wr;
  logic         out_data_valid;
  logic         out_ready;
  logic [31:0]  pkt_cnt;
  logic [31:0]  drop_cnt;

  logic [133:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tail_cyc = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  logic prev_vwr = 1'b0;
  logic in_pkt = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pkt_egress_buffer #(
    .DEPTH_LOG2    (DL),
    .MAX_PKT_FLITS (MAXF)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_data_wr        (in_data_wr),
    .in_data           (in_data),
    .in_data_valid_wr  (in_data_valid_wr),
    .in_data_valid     (in_data_valid),
    .in_ready          (in_ready),
    .out_data_wr       (out_data_wr),
    .out_data          (out_data),
    .out_data_valid_wr (out_data_valid_wr),
    .out_data_valid    (out_data_valid),
    .out_ready         (out_ready),
    .pkt_cnt           (pkt_cnt),
    .drop_cnt          (drop_cnt)
  );

  task automatic check_val(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [133:0] mk_flit(input logic [1:0] t, input int pid, input int idx);
    logic [131:0] p;
    p = {pid[15:0], idx[15:0], $urandom(), $urandom(), $urandom(), 4'h5};
    return {t, p};
  endfunction

  task automatic drive_flit(input logic [133:0] f, input logic vwr, input logic v);
    @(negedge clk);
    in_data_wr       = 1'b1;
    in_data          = f;
    in_data_valid_wr = vwr;
    in_data_valid    = v;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_data_wr       = 1'b0;
    in_data_valid_wr = 1'b0;
    in_data_valid    = 1'b0;
  endtask

  // Sends an n-flit packet; keep=1 pushes its flits onto the scoreboard.
  task automatic send_pkt(input int n, input logic v, input logic keep, input int pid);
    logic [1:0] t;
    logic [133:0] f;
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? T_HEAD : ((i == n - 1) ? T_TAIL : T_BODY);
      f = mk_flit(t, pid, i);
      drive_flit(f, t == T_TAIL, v && (t == T_TAIL));
      if (keep) exp_q.push_back(f);
      if (t == T_TAIL) tail_cyc = cyc;
    end
    idle_in();
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_pkt) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_drain"}, 134'(exp_q.size()), 134'(0));
    repeat (4) @(negedge clk);
    check_val({tag, "_pkt_cnt"}, 134'(pkt_cnt), 134'(exp_pkt));
    check_val({tag, "_drop_cnt"}, 134'(drop_cnt), 134'(exp_drop));
  endtask

  // Output monitor: pops the scoreboard on every output flit.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt   <= 1'b0;
      prev_vwr <= 1'b0;
    end else begin
      if (out_data_wr) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_flit", 134'(out_data_wr), 134'(0));
        end else begin
          check_val("out_data", out_data, exp_q[0]);
          check_val("out_vwr", 134'(out_data_valid_wr), 134'(exp_q[0][133:132] == T_TAIL));
          check_val("out_valid", 134'(out_data_valid), 134'(exp_q[0][133:132] == T_TAIL));
          if (exp_q[0][133:132] == T_HEAD) check_val("idle_gap", 134'(prev_vwr), 134'(0));
          void'(exp_q.pop_front());
        end
        in_pkt <= (out_data[133:132] != T_TAIL);
      end else begin
        if (in_pkt) check_val("stall", 134'(out_data_wr), 134'(1));
        if (out_data_valid_wr || out_data_valid)
          check_val("idle_status", 134'({out_data_valid_wr, out_data_valid}), 134'(0));
      end
      prev_vwr <= out_data_valid_wr;
    end
  end

  initial begin
    int k;
    logic saw_low;
    logic [1:0] t;
    rst_n            = 1'b0;
    in_data_wr       = 1'b0;
    in_data          = '0;
    in_data_valid_wr = 1'b0;
    in_data_valid    = 1'b0;
    out_ready        = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 134'(in_ready), 134'(0));
    check_val("rst_out_wr", 134'(out_data_wr), 134'(0));
    check_val("rst_out_data", out_data, 134'(0));
    check_val("rst_vwr", 134'({out_data_valid_wr, out_data_valid}), 134'(0));
    check_val("rst_cnts", 134'({pkt_cnt, drop_cnt}), 134'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_in_ready", 134'(in_ready), 134'(1));

    // Single 4-flit packet, head at tail cycle + 2.
    out_ready = 1'b1;
    send_pkt(4, 1'b1, 1'b1, 1);
    exp_pkt++;
    k = 0;
    while (!out_data_wr && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("t1_latency", 134'(cyc - tail_cyc), 134'(2));
    wait_drain("t1");

    // Dropped 3-flit packet, then a valid 2-flit packet.
    send_pkt(3, 1'b0, 1'b0, 2);
    exp_drop++;
    send_pkt(2, 1'b1, 1'b1, 3);
    exp_pkt++;
    wait_drain("t2");

    // Head, body, new head (missing tail), then a valid 3-flit packet.
    drive_flit(mk_flit(T_HEAD, 4, 0), 1'b0, 1'b0);
    drive_flit(mk_flit(T_BODY, 4, 1), 1'b0, 1'b0);
    send_pkt(3, 1'b1, 1'b1, 5);
    exp_drop++;
    exp_pkt++;
    wait_drain("t3");

    // 20-flit packet into a 16-flit buffer: truncated and dropped.
    out_ready = 1'b0;
    saw_low   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      t = (i == 0) ? T_HEAD : ((i == 19) ? T_TAIL : T_BODY);
      drive_flit(mk_flit(t, 6, i), t == T_TAIL, t == T_TAIL);
      if (!in_ready) saw_low = 1'b1;
    end
    idle_in();
    exp_drop++;
    check_val("t4_ready_low", 134'(saw_low), 134'(1));
    repeat (3) @(negedge clk);
    check_val("t4_ready_back", 134'(in_ready), 134'(1));
    wait_drain("t4");

    // Three packets committed while blocked, then released in order.
    send_pkt(2, 1'b1, 1'b1, 7);
    send_pkt(3, 1'b1, 1'b1, 8);
    send_pkt(4, 1'b1, 1'b1, 9);
    exp_pkt += 3;
    repeat (5) @(negedge clk);
    check_val("t5_held", 134'(exp_q.size()), 134'(9));
    out_ready = 1'b1;
    wait_drain("t5");

    // Reset in the middle of replaying a 6-flit packet.
    send_pkt(6, 1'b1, 1'b1, 10);
    k = 0;
    while (!out_data_wr && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t6_out_wr", 134'(out_data_wr), 134'(0));
    check_val("t6_out_data", out_data, 134'(0));
    check_val("t6_vwr", 134'({out_data_valid_wr, out_data_valid}), 134'(0));
    check_val("t6_in_ready", 134'(in_ready), 134'(0));
    check_val("t6_cnts", 134'({pkt_cnt, drop_cnt}), 134'(0));
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6_ready_back", 134'(in_ready), 134'(1));
    repeat (12) @(negedge clk);
    send_pkt(2, 1'b1, 1'b1, 11);
    exp_pkt++;
    wait_drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_egress_buffer.md
Name: pkt_egress_buffer

Overview:
- Store-and-forward packet buffer placed directly downstream of the UM packet mux.
- Accepts the 134-bit flit stream: [133:132] = 2'b01 head, 2'b00 body, 2'b10 tail.
- Commits a packet only when its tail carries valid=1. Otherwise the whole packet is rolled back and dropped.
- Replays committed packets to the physical/DMA output port, one whole packet per grant.

Parameters:
- DEPTH_LOG2, 9: data FIFO depth is 2^DEPTH_LOG2 flits.
- MAX_PKT_FLITS, 100: worst-case packet length in flits; used for in_ready.
- Constraint: MAX_PKT_FLITS < 2^DEPTH_LOG2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data_wr  in  1  input flit strobe
- in_data  in  134  input flit
- in_data_valid_wr  in  1  packet-status strobe; coincident with the tail flit
- in_data_valid  in  1  1 = keep packet, 0 = drop packet
- in_ready  out  1  upstream may start a new packet
- out_data_wr  out  1  output flit strobe
- out_data  out  134  output flit
- out_data_valid_wr  out  1  status strobe, asserted with the output tail
- out_data_valid  out  1  always 1 with out_data_valid_wr
- out_ready  in  1  downstream accepts a new packet; sampled only in IDLE
- pkt_cnt  out  32  committed packets, wraps
- drop_cnt  out  32  dropped/truncated packets, wraps

Behaviour:
- Reset state: all outputs 0, including in_ready, out_data and both counters. Pointers 0, pkts_avail 0, write FSM W_IDLE, read FSM R_IDLE. Reset mid-packet discards everything.
- Storage:
  - Dual-pointer memory with (DEPTH_LOG2+1)-bit wr_ptr, commit_ptr and rd_ptr.
  - used = commit_ptr - rd_ptr, modulo arithmetic.
  - Full when wr_ptr - rd_ptr == 2^DEPTH_LOG2.
- in_ready: registered. Next value = (2^DEPTH_LOG2 - (wr_ptr - rd_ptr)) >= MAX_PKT_FLITS. Upstream checks it only before a head flit.
- Write FSM, W_IDLE:
  - Head flit: write it, wr_ptr++, go to W_PKT.
  - Body or tail flit: ignore it, no counter change.
  - Type 2'b11: ignore it.
- Write FSM, W_PKT:
  - Body flit: write it, wr_ptr++.
  - Tail flit: write it.
    - If in_data_valid_wr=1, in_data_valid=1 and no truncation: commit_ptr <= wr_ptr+1, pkts_avail++, pkt_cnt++.
    - Otherwise: wr_ptr <= commit_ptr (rollback), drop_cnt++.
    - In both cases go to W_IDLE.
  - Head flit (missing tail): roll back the partial packet, drop_cnt++, then treat the flit as a new head in the same cycle.
  - Flit arriving while full: not written; set trunc flag; the packet is dropped at its tail.
- Read FSM:
  - R_IDLE: when pkts_avail != 0 and out_ready=1, go to R_SEND and issue a read at rd_ptr.
  - R_SEND: one read per cycle, no stalls.
  - Memory read latency is 1 cycle. out_data and out_data_wr=1 are registered in the cycle after each read.
  - When the flit read has type 2'b10: out_data_valid_wr=1 and out_data_valid=1 in the same cycle as that flit, pkts_avail--, return to R_IDLE.
  - out_data_wr, out_data_valid_wr and out_data_valid are 0 whenever no flit is driven; out_data holds its last value.
- Simultaneous events:
  - Commit and tail-out in the same cycle: pkts_avail unchanged.
  - Read and write in the same cycle: both proceed; only committed addresses are read.
- Latency: tail-commit at cycle T, out_ready=1 → head flit on out_data at T+2. A packet of N flits occupies the output for N consecutive cycles.
- Back-to-back packets: one idle cycle minimum between an output tail and the next head.

Decomposition:
- Shared package pkt_defs_pkg:
  - FLIT_W=134.
  - FLIT_HEAD=2'b01, FLIT_BODY=2'b00, FLIT_TAIL=2'b10.
  - Type-field slice [133:132].
  - W_IDLE/W_PKT and R_IDLE/R_SEND encodings.
- Natural sub-module: pkt_buf_ram, a simple dual-port RAM of 2^DEPTH_LOG2 x 134 with registered read. It is the vendor-swappable piece for Xilinx or Altera.

Test Plan:
- Single 4-flit packet (01,00,00,10), tail valid=1, out_ready=1 → same 4 flits out in consecutive cycles starting T+2. out_data_valid_wr=1 only with the tail; pkt_cnt=1.
- 3-flit packet with tail valid=0, then a 2-flit valid packet → only the 2-flit packet is output; drop_cnt=1, pkt_cnt=1; write pointer back at the first packet's start (verify via used=2 after commit).
- Head, body, then a new head (missing tail), then a full valid 3-flit packet → only the 3-flit packet is output; drop_cnt=1.
- DEPTH_LOG2=4, MAX_PKT_FLITS=8, out_ready=0, write 20-flit packet ignoring in_ready → truncated and dropped, drop_cnt=1, nothing output. in_ready goes 0 during the fill and returns to 1 after rollback.
- Three valid packets committed while out_ready=0; then out_ready=1 → all three output in order, each separated by at least one idle cycle; pkt_cnt=3.
- Assert rst_n low during R_SEND of a 6-flit packet → all outputs 0 immediately. After release, no residual flits are output and in_ready returns to 1 next cycle.
